// File: rtl/rs_syn_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rs_syn_frame_ctrl
// Function : Frames the symbol stream for the RS syndrome datapath and buffers
//            its syndrome results in a 2-entry FIFO for the key-equation solver.
// Revision : 1.0  initial release
// ============================================================================
module rs_syn_frame_ctrl #(
    parameter int SYM_BW = 8,
    parameter int N_NUM  = 255,
    parameter int R_NUM  = 16,
    parameter int CNT_BW = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_val,
    input  logic                    s_sop,
    input  logic [SYM_BW-1:0]       s_data,
    output logic                    s_ready,
    output logic                    syn_din_val,
    output logic                    syn_din_sop,
    output logic                    syn_din_eop,
    output logic [SYM_BW-1:0]       syn_din,
    input  logic                    syn_val,
    input  logic [SYM_BW*R_NUM-1:0] syn_bus,
    output logic                    o_val,
    input  logic                    o_ready,
    output logic [SYM_BW*R_NUM-1:0] o_synd,
    output logic                    o_err_free,
    output logic                    err_abort,
    output logic                    err_nosop
);

    localparam int SYN_W = SYM_BW * R_NUM;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    logic [CNT_BW-1:0]  r_sym_cnt;
    logic               r_pending;
    logic               r_err_abort;
    logic               r_err_nosop;
    logic [1:0]         r_fifo_cnt;
    logic [SYN_W-1:0]   r_head_synd;
    logic [SYN_W-1:0]   r_tail_synd;
    logic               r_head_ef;
    logic               r_tail_ef;

    logic               w_run;
    logic               w_acc;
    logic               w_pop;
    logic               w_push;
    logic               w_last;
    logic               w_in_ef;
    logic [2:0]         w_occ;

    assign w_run   = (r_state == ST_RUN);
    assign w_pop   = o_val & o_ready;
    assign w_push  = syn_val & r_pending;
    assign w_last  = (r_sym_cnt == CNT_BW'(N_NUM - 1));
    assign w_in_ef = (syn_bus == '0);

    // Occupancy counts buffered, in-flight and in-progress results so a new
    // frame only starts when its syndrome is guaranteed a FIFO slot.
    assign w_occ   = {1'b0, r_fifo_cnt} + {2'b00, r_pending} + {2'b00, w_run};
    assign s_ready = w_run | (w_occ < 3'd2) | w_pop;
    assign w_acc   = s_val & s_ready;

    assign syn_din     = s_data;
    assign syn_din_val = w_acc & (w_run | s_sop);
    assign syn_din_sop = w_acc & s_sop;
    assign syn_din_eop = w_acc & w_run & ~s_sop & w_last;

    assign o_val      = (r_fifo_cnt != 2'd0);
    assign o_synd     = r_head_synd;
    assign o_err_free = r_head_ef;
    assign err_abort  = r_err_abort;
    assign err_nosop  = r_err_nosop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_sym_cnt   <= '0;
            r_pending   <= 1'b0;
            r_err_abort <= 1'b0;
            r_err_nosop <= 1'b0;
        end else begin
            r_err_abort <= 1'b0;
            r_err_nosop <= 1'b0;
            if (syn_din_eop)
                r_pending <= 1'b1;
            else if (w_push)
                r_pending <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_acc) begin
                        if (s_sop) begin
                            r_state   <= ST_RUN;
                            r_sym_cnt <= CNT_BW'(1);
                        end else begin
                            r_err_nosop <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    // The datapath clears on any idle cycle, so a gap kills the frame.
                    if (!s_val) begin
                        r_err_abort <= 1'b1;
                        r_state     <= ST_IDLE;
                        r_sym_cnt   <= '0;
                    end else if (s_sop) begin
                        r_err_abort <= 1'b1;
                        r_sym_cnt   <= CNT_BW'(1);
                    end else if (w_last) begin
                        r_state   <= ST_IDLE;
                        r_sym_cnt <= '0;
                    end else begin
                        r_sym_cnt <= r_sym_cnt + CNT_BW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fifo_cnt  <= 2'd0;
            r_head_synd <= '0;
            r_tail_synd <= '0;
            r_head_ef   <= 1'b0;
            r_tail_ef   <= 1'b0;
        end else begin
            case (r_fifo_cnt)
                2'd0: begin
                    if (w_push) begin
                        r_head_synd <= syn_bus;
                        r_head_ef   <= w_in_ef;
                        r_fifo_cnt  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (w_push && w_pop) begin
                        r_head_synd <= syn_bus;
                        r_head_ef   <= w_in_ef;
                    end else if (w_push) begin
                        r_tail_synd <= syn_bus;
                        r_tail_ef   <= w_in_ef;
                        r_fifo_cnt  <= 2'd2;
                    end else if (w_pop) begin
                        r_fifo_cnt <= 2'd0;
                    end
                end
                2'd2: begin
                    if (w_pop) begin
                        r_head_synd <= r_tail_synd;
                        r_head_ef   <= r_tail_ef;
                        if (w_push) begin
                            r_tail_synd <= syn_bus;
                            r_tail_ef   <= w_in_ef;
                        end else begin
                            r_fifo_cnt <= 2'd1;
                        end
                    end
                end
                default: r_fifo_cnt <= 2'd0;
            endcase
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(w_push && (r_fifo_cnt == 2'd2) && !w_pop));
            assert (!(syn_val && !r_pending));
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rs_syn_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rs_syn_frame_ctrl
// Function : Directed bench for rs_syn_frame_ctrl with a GF(2^8) syndrome model.
// Revision : 1.0  initial release
// ============================================================================
module tb_rs_syn_frame_ctrl;

    localparam int SYM_BW = 8;
    localparam int N_NUM  = 255;
    localparam int R_NUM  = 16;
    localparam int CNT_BW = 8;
    localparam int SYN_W  = SYM_BW * R_NUM;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               s_val, s_sop, s_ready;
    logic [SYM_BW-1:0]  s_data;
    logic               syn_din_val, syn_din_sop, syn_din_eop;
    logic [SYM_BW-1:0]  syn_din;
    logic               syn_val;
    logic [SYN_W-1:0]   syn_bus;
    logic               o_val, o_ready, o_err_free, err_abort, err_nosop;
    logic [SYN_W-1:0]   o_synd;

    int checks = 0;
    int failures = 0;
    int n_abort = 0, n_nosop = 0, n_pop = 0, n_oval = 0;
    logic [SYN_W:0] pop_q[$];

    always #5 clk = ~clk;

    rs_syn_frame_ctrl #(.SYM_BW(SYM_BW), .N_NUM(N_NUM), .R_NUM(R_NUM), .CNT_BW(CNT_BW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_val(s_val), .s_sop(s_sop), .s_data(s_data), .s_ready(s_ready),
        .syn_din_val(syn_din_val), .syn_din_sop(syn_din_sop), .syn_din_eop(syn_din_eop),
        .syn_din(syn_din), .syn_val(syn_val), .syn_bus(syn_bus),
        .o_val(o_val), .o_ready(o_ready), .o_synd(o_synd), .o_err_free(o_err_free),
        .err_abort(err_abort), .err_nosop(err_nosop)
    );

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1D) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [7:0] gf_pow(input int e);
        logic [7:0] p;
        p = 8'h01;
        for (int i = 0; i < e; i++) p = gf_mul(p, 8'h02);
        return p;
    endfunction

    // Single error of value val at symbol pos of an all-zero codeword: S_j = val * alpha^(j*(N-1-pos)).
    function automatic logic [SYN_W-1:0] exp_synd(input int pos, input logic [7:0] val);
        logic [SYN_W-1:0] r;
        r = '0;
        for (int j = 1; j <= R_NUM; j++)
            r[(j-1)*8 +: 8] = gf_mul(val, gf_pow((j * (N_NUM - 1 - pos)) % 255));
        return r;
    endfunction

    function automatic logic [7:0] horner(input logic [7:0] acc, input int j,
                                          input logic [7:0] din, input logic sop);
        return sop ? din : (gf_mul(acc, gf_pow(j)) ^ din);
    endfunction

    logic [7:0] m_acc [1:R_NUM];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syn_val <= 1'b0;
            syn_bus <= '0;
            for (int j = 1; j <= R_NUM; j++) m_acc[j] <= 8'h00;
        end else begin
            syn_val <= syn_din_eop;
            for (int j = 1; j <= R_NUM; j++) begin
                m_acc[j] <= syn_din_val ? horner(m_acc[j], j, syn_din, syn_din_sop) : 8'h00;
                if (syn_din_eop) syn_bus[(j-1)*8 +: 8] <= horner(m_acc[j], j, syn_din, 1'b0);
            end
        end
    end

    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            if (err_abort) n_abort++;
            if (err_nosop) n_nosop++;
            if (o_val) n_oval++;
            if (o_val && o_ready) begin
                n_pop++;
                pop_q.push_back({o_synd, o_err_free});
            end
        end
    end

    task automatic check(input string tag, input logic [SYN_W:0] obs, input logic [SYN_W:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic sop, input logic [7:0] d);
        int t;
        @(negedge clk);
        s_val = 1'b1; s_sop = sop; s_data = d;
        #1;
        t = 0;
        while (!s_ready && t < 1000) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (t != 0) check("s_ready_wait", {{SYN_W{1'b0}}, s_ready}, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            s_val = 1'b0; s_sop = 1'b0; s_data = 8'h00;
            #1;
        end
    endtask

    task automatic send_frame(input int pos, input logic [7:0] val);
        for (int i = 0; i < N_NUM; i++) send(i == 0, (i == pos) ? val : 8'h00);
    endtask

    int p0, a0, q0, v0, ns0;

    initial begin
        s_val = 1'b0; s_sop = 1'b0; s_data = 8'h00; o_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_o_val", o_val, 0);
        check("rst_o_synd", o_synd, 0);
        check("rst_o_err_free", o_err_free, 0);
        check("rst_err_abort", err_abort, 0);
        check("rst_err_nosop", err_nosop, 0);
        check("rst_s_ready", s_ready, 1);
        @(negedge clk); rst_n = 1'b1;

        // Single clean frame
        p0 = n_pop; q0 = pop_q.size();
        for (int i = 0; i < N_NUM; i++) begin
            send(i == 0, 8'h00);
            if (i == 0) check("t1_din_sop", {syn_din_val, syn_din_sop}, 2'b11);
            if (i == N_NUM - 2) check("t1_eop_early", syn_din_eop, 0);
            if (i == N_NUM - 1) check("t1_eop_last", syn_din_eop, 1);
        end
        idle(1);
        check("t1_oval_t1", o_val, 0);
        idle(1);
        check("t1_oval_t2", o_val, 1);
        check("t1_synd", o_synd, 0);
        check("t1_err_free", o_err_free, 1);
        idle(1);
        check("t1_oval_after", o_val, 0);
        check("t1_pops", n_pop - p0, 1);
        if (pop_q.size() > q0) check("t1_qsynd", pop_q[q0], {exp_synd(0, 8'h00), 1'b1});

        // Single-symbol error
        p0 = n_pop; q0 = pop_q.size(); v0 = n_oval;
        send_frame(10, 8'h01);
        idle(4);
        check("t2_pops", n_pop - p0, 1);
        check("t2_oval_cycles", n_oval - v0, 1);
        if (pop_q.size() > q0) check("t2_synd", pop_q[q0], {exp_synd(10, 8'h01), 1'b0});

        // Gap abort, then stray symbols, then a good frame
        a0 = n_abort; v0 = n_oval;
        for (int i = 0; i < 100; i++) send(i == 0, 8'h00);
        idle(1);
        ns0 = n_nosop;
        for (int i = 0; i < 150; i++) send(1'b0, 8'hA5);
        idle(3);
        check("t3_abort", n_abort - a0, 1);
        check("t3_nosop", n_nosop - ns0, 150);
        check("t3_no_oval", n_oval - v0, 0);
        p0 = n_pop; q0 = pop_q.size();
        send_frame(20, 8'h55);
        idle(4);
        check("t3_pops", n_pop - p0, 1);
        if (pop_q.size() > q0) check("t3_synd", pop_q[q0], {exp_synd(20, 8'h55), 1'b0});

        // Backpressure with three back-to-back frames
        o_ready = 1'b0;
        q0 = pop_q.size();
        send_frame(10, 8'h01);
        send_frame(10, 8'h02);
        @(negedge clk);
        s_val = 1'b1; s_sop = 1'b1; s_data = 8'h00;
        #1;
        check("t4_blocked_a", s_ready, 0);
        repeat (3) begin @(negedge clk); #1; end
        check("t4_blocked_b", s_ready, 0);
        check("t4_oval_hold", o_val, 1);
        check("t4_synd_hold", {o_synd, o_err_free}, {exp_synd(10, 8'h01), 1'b0});
        @(negedge clk);
        o_ready = 1'b1;
        #1;
        check("t4_unblocked", s_ready, 1);
        for (int i = 1; i < N_NUM; i++) send(1'b0, (i == 10) ? 8'h03 : 8'h00);
        idle(4);
        check("t4_pops", pop_q.size() - q0, 3);
        if (pop_q.size() >= q0 + 3) begin
            check("t4_first", pop_q[q0], {exp_synd(10, 8'h01), 1'b0});
            check("t4_second", pop_q[q0+1], {exp_synd(10, 8'h02), 1'b0});
            check("t4_third", pop_q[q0+2], {exp_synd(10, 8'h03), 1'b0});
        end

        // Early sop restarts the frame
        a0 = n_abort; p0 = n_pop; q0 = pop_q.size();
        for (int i = 0; i < 50; i++) send(i == 0, 8'h00);
        for (int i = 0; i < N_NUM; i++) begin
            send(i == 0, (i == 10) ? 8'h07 : 8'h00);
            if (i == N_NUM - 2) check("t5_eop_early", syn_din_eop, 0);
            if (i == N_NUM - 1) check("t5_eop_last", syn_din_eop, 1);
        end
        idle(4);
        check("t5_abort", n_abort - a0, 1);
        check("t5_pops", n_pop - p0, 1);
        if (pop_q.size() > q0) check("t5_synd", pop_q[q0], {exp_synd(10, 8'h07), 1'b0});

        // Reset with one buffered entry and one pending result
        o_ready = 1'b0;
        send_frame(10, 8'h01);
        send_frame(10, 8'h02);
        @(negedge clk);
        s_val = 1'b0; s_sop = 1'b0;
        #1;
        check("t6_pre_oval", o_val, 1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_oval", o_val, 0);
        check("t6_rst_synd", o_synd, 0);
        @(negedge clk);
        rst_n = 1'b1;
        o_ready = 1'b1;
        #1;
        check("t6_s_ready", s_ready, 1);
        idle(3);
        check("t6_oval_stays", o_val, 0);
        send(1'b0, 8'h11);
        idle(1);
        check("t6_idle_nosop", err_nosop, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rs_syn_frame_ctrl.md
Name: rs_syn_frame_ctrl

Overview:
- Frame sequencer and result buffer in front of the RS decoder syndrome datapath.
- Accepts a symbol stream with valid/ready and start-of-frame marking.
- Counts symbols, generates the datapath's din_val/din_sop/din_eop strobes, and aborts frames whose symbol stream is not contiguous, because the datapath clears its accumulator on any idle cycle.
- Captures the syndrome vector on syndrome_val into a 2-entry output FIFO with a no-error flag; the FIFO feeds the key-equation solver over a valid/ready handshake.

Parameters:
- SYM_BW, 8, symbol width in bits (3..8).
- N_NUM, 255, codeword length in symbols (2..255).
- R_NUM, 16, number of check symbols / syndromes.
- CNT_BW, 8, symbol counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- s_val  in  1  input symbol valid
- s_sop  in  1  input symbol is first of codeword
- s_data  in  SYM_BW  input symbol
- s_ready  out  1  block accepts symbol this cycle
- syn_din_val  out  1  to datapath din_val
- syn_din_sop  out  1  to datapath din_sop
- syn_din_eop  out  1  to datapath din_eop
- syn_din  out  SYM_BW  to datapath din
- syn_val  in  1  from datapath syndrome_val
- syn_bus  in  SYM_BW*R_NUM  from datapath syndrome
- o_val  out  1  FIFO head valid
- o_ready  in  1  downstream pops head
- o_synd  out  SYM_BW*R_NUM  FIFO head syndrome vector
- o_err_free  out  1  head syndrome is all-zero
- err_abort  out  1  one-cycle pulse: frame aborted
- err_nosop  out  1  one-cycle pulse: symbol dropped in IDLE without sop

Behaviour:
- States: IDLE, RUN. Reset: IDLE, sym_cnt=0, pending=0, FIFO empty. Reset values: o_val=0, o_synd=0, o_err_free=0, err_abort=0, err_nosop=0.
- acc = s_val & s_ready. pop = o_val & o_ready.
- occ = fifo_cnt + pending + (state==RUN).
- s_ready = 1 in RUN. In IDLE, s_ready = (occ<2) | pop.
- syn_din_* are combinational, with syn_din = s_data:
  - syn_din_val = acc & (RUN | s_sop).
  - syn_din_sop = acc & s_sop.
  - syn_din_eop = acc & RUN & ~s_sop & (sym_cnt==N_NUM-1).
- IDLE behaviour:
  - acc & s_sop: go to RUN, sym_cnt=1.
  - acc & ~s_sop: symbol dropped, err_nosop pulses next cycle.
- RUN behaviour:
  - acc & ~s_sop: sym_cnt++.
  - On the eop symbol: go to IDLE, set pending=1.
  - ~s_val: abort. err_abort pulses, go to IDLE, no capture.
  - acc & s_sop (early sop): err_abort pulses, sym_cnt=1, stay in RUN; the new frame starts on that symbol.
- Capture: when syn_val=1, push {syn_bus, (syn_bus==0)} into the FIFO and clear pending. syn_val arrives the cycle after eop.
- Latency: eop symbol accepted at cycle t; syn_val at t+1; o_val=1 at t+2 when the FIFO was empty.
- FIFO:
  - 2 entries, registered head, first-in first-out.
  - Simultaneous push and pop is allowed at any count.
  - The occ gating guarantees the FIFO is never pushed when full. A push while full is a design error (simulation assertion).
  - o_synd and o_err_free hold their value while o_val=1 and o_ready=0.
- Back-to-back codewords: a sop in the cycle after eop is accepted if occ<2 or pop.
- syn_val with pending=0 is ignored (assertion).
- Reset mid-frame: returns to IDLE with the FIFO flushed. The datapath is reset by the same rst_n.

Test Plan:
- Single frame: N_NUM=255, data all 0x00, sop on symbol 0, contiguous, o_ready=1 -> syn_din_eop on symbol 254; o_val=1 two cycles later with o_synd=0, o_err_free=1.
- Erroneous frame: valid codeword with symbol 10 XOR 0x01 -> o_err_free=0, o_synd matches the golden model, o_val for exactly one cycle.
- Gap abort: drop s_val for 1 cycle at symbol 100 -> err_abort pulse, no o_val. The next 150 symbols without sop each raise err_nosop. The next sop frame completes normally.
- Backpressure: o_ready=0, three back-to-back frames -> first two buffered. s_ready=0 in IDLE at the third sop until o_ready=1. All three syndromes pop in order.
- Early sop: sop at symbol 50 of a frame -> err_abort pulse, sym_cnt restarts; eop 254 symbols after the second sop; one result only.
- Reset with pending result and 1 FIFO entry -> o_val=0, s_ready=1 after reset release, state IDLE.
